// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared LFSR tap table, draw FSM state encoding, lock-up constant.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // An XNOR LFSR sticks forever in the all-ones state.
    localparam logic [31:0] c_LOCKUP = 32'hFFFF_FFFF;

    function automatic logic [31:0] tap(input int unsigned pos);
        return 32'd1 << (pos - 1);
    endfunction

    // Maximal-length tap positions (1-based), Xilinx XAPP052 table.
    function automatic logic [31:0] lfsr_taps(input int unsigned num_bits);
        logic [31:0] mask;
        mask = 32'd0;
        case (num_bits)
            3:  mask = tap(3)  | tap(2);
            4:  mask = tap(4)  | tap(3);
            5:  mask = tap(5)  | tap(3);
            6:  mask = tap(6)  | tap(5);
            7:  mask = tap(7)  | tap(6);
            8:  mask = tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  mask = tap(9)  | tap(5);
            10: mask = tap(10) | tap(7);
            11: mask = tap(11) | tap(9);
            12: mask = tap(12) | tap(6)  | tap(4)  | tap(1);
            13: mask = tap(13) | tap(4)  | tap(3)  | tap(1);
            14: mask = tap(14) | tap(5)  | tap(3)  | tap(1);
            15: mask = tap(15) | tap(14);
            16: mask = tap(16) | tap(15) | tap(13) | tap(4);
            17: mask = tap(17) | tap(14);
            18: mask = tap(18) | tap(11);
            19: mask = tap(19) | tap(6)  | tap(2)  | tap(1);
            20: mask = tap(20) | tap(17);
            21: mask = tap(21) | tap(19);
            22: mask = tap(22) | tap(21);
            23: mask = tap(23) | tap(18);
            24: mask = tap(24) | tap(23) | tap(22) | tap(17);
            25: mask = tap(25) | tap(22);
            26: mask = tap(26) | tap(6)  | tap(2)  | tap(1);
            27: mask = tap(27) | tap(5)  | tap(2)  | tap(1);
            28: mask = tap(28) | tap(25);
            29: mask = tap(29) | tap(27);
            30: mask = tap(30) | tap(6)  | tap(4)  | tap(1);
            31: mask = tap(31) | tap(28);
            32: mask = tap(32) | tap(22) | tap(2)  | tap(1);
            default: mask = 32'd0;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core
// Purpose  : XNOR Fibonacci LFSR register, feedback and latched seed.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int                  NUM_BITS     = 11,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = '0
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Step,
    input  logic                i_Load,
    input  logic [NUM_BITS-1:0] i_Load_Data,
    output logic [NUM_BITS-1:0] o_State,
    output logic [NUM_BITS-1:0] o_Seed,
    output logic [NUM_BITS-1:0] o_Next,
    output logic                o_Fb
);

    localparam logic [31:0]         c_TAPS = lfsr_taps(NUM_BITS);
    localparam logic [NUM_BITS-1:0] c_MASK = c_TAPS[NUM_BITS-1:0];

    logic [NUM_BITS-1:0] r_lfsr_q, w_lfsr_d;
    logic [NUM_BITS-1:0] r_seed_q, w_seed_d;
    logic                w_fb;
    logic [NUM_BITS-1:0] w_next;

    // All tap sets hold an even number of taps, so a reduction XNOR equals the XNOR chain.
    assign w_fb   = ~^(r_lfsr_q & c_MASK);
    assign w_next = {r_lfsr_q[NUM_BITS-2:0], w_fb};

    always_comb begin
        w_lfsr_d = r_lfsr_q;
        w_seed_d = r_seed_q;
        if (i_Load) begin
            w_lfsr_d = i_Load_Data;
            w_seed_d = i_Load_Data;
        end else if (i_Step) begin
            w_lfsr_d = w_next;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_lfsr_q <= DEFAULT_SEED;
            r_seed_q <= DEFAULT_SEED;
        end else begin
            r_lfsr_q <= w_lfsr_d;
            r_seed_q <= w_seed_d;
        end
    end

    assign o_State = r_lfsr_q;
    assign o_Seed  = r_seed_q;
    assign o_Next  = w_next;
    assign o_Fb    = w_fb;

endmodule
`default_nettype wire

// File: rtl/lfsr_prng.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_prng
// Purpose  : LFSR PRNG with request/valid draws, seed rejection, period detect.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int                  NUM_BITS     = 11,
    parameter int                  OUT_BITS     = 8,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = '0
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    input  logic                i_Req,
    output logic                o_Busy,
    output logic                o_Valid,
    output logic [OUT_BITS-1:0] o_Rand_Data,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic [NUM_BITS-1:0] o_Step_Count,
    output logic                o_Period_Done,
    output logic                o_Seed_Err
);

    localparam int               c_CNT_W    = $clog2(OUT_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_OUT_LAST = c_CNT_W'(OUT_BITS);

    state_t              r_state_q,       w_state_d;
    logic [c_CNT_W-1:0]  r_bit_cnt_q,     w_bit_cnt_d;
    logic [OUT_BITS-1:0] r_collect_q,     w_collect_d;
    logic [OUT_BITS-1:0] r_rand_q,        w_rand_d;
    logic                r_valid_q,       w_valid_d;
    logic [NUM_BITS-1:0] r_step_cnt_q,    w_step_cnt_d;
    logic                r_period_done_q, w_period_done_d;
    logic                r_seed_err_q,    w_seed_err_d;

    logic                w_step;
    logic                w_load;
    logic [NUM_BITS-1:0] w_load_data;
    logic [NUM_BITS-1:0] w_state;
    logic [NUM_BITS-1:0] w_seed;
    logic [NUM_BITS-1:0] w_next;
    logic                w_fb;
    logic                w_seed_lockup;

    assign w_seed_lockup = (i_Seed_Data == c_LOCKUP[NUM_BITS-1:0]);

    lfsr_core #(
        .NUM_BITS     (NUM_BITS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Step      (w_step),
        .i_Load      (w_load),
        .i_Load_Data (w_load_data),
        .o_State     (w_state),
        .o_Seed      (w_seed),
        .o_Next      (w_next),
        .o_Fb        (w_fb)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_collect_d  = r_collect_q;
        w_rand_d     = r_rand_q;
        w_valid_d    = 1'b0;
        w_seed_err_d = 1'b0;
        w_step       = 1'b0;
        w_load       = 1'b0;
        w_load_data  = i_Seed_Data;
        case (r_state_q)
            IDLE: begin
                if (i_Seed_DV) begin
                    w_load = 1'b1;
                    if (w_seed_lockup) begin
                        w_load_data  = DEFAULT_SEED;
                        w_seed_err_d = 1'b1;
                    end
                end else if (i_Req) begin
                    w_state_d   = SHIFT;
                    w_bit_cnt_d = '0;
                end else if (i_Enable) begin
                    w_step = 1'b1;
                end
            end
            SHIFT: begin
                w_seed_err_d = i_Seed_DV;
                if (r_bit_cnt_q != c_OUT_LAST) begin
                    w_step      = 1'b1;
                    w_collect_d = (r_collect_q << 1) | OUT_BITS'(w_fb);
                    w_bit_cnt_d = r_bit_cnt_q + c_CNT_W'(1);
                end else begin
                    // Result and valid are registered together so they appear in DONE.
                    w_state_d = DONE;
                    w_rand_d  = r_collect_q;
                    w_valid_d = 1'b1;
                end
            end
            DONE: begin
                w_seed_err_d = i_Seed_DV;
                w_state_d    = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Period is measured against the latched seed, so a wrap restarts the count.
    always_comb begin
        w_step_cnt_d    = r_step_cnt_q;
        w_period_done_d = 1'b0;
        if (w_load) begin
            w_step_cnt_d = '0;
        end else if (w_step) begin
            if (w_next == w_seed) begin
                w_period_done_d = 1'b1;
                w_step_cnt_d    = '0;
            end else begin
                w_step_cnt_d = r_step_cnt_q + NUM_BITS'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state_q       <= IDLE;
            r_bit_cnt_q     <= '0;
            r_collect_q     <= '0;
            r_rand_q        <= '0;
            r_valid_q       <= 1'b0;
            r_step_cnt_q    <= '0;
            r_period_done_q <= 1'b0;
            r_seed_err_q    <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_bit_cnt_q     <= w_bit_cnt_d;
            r_collect_q     <= w_collect_d;
            r_rand_q        <= w_rand_d;
            r_valid_q       <= w_valid_d;
            r_step_cnt_q    <= w_step_cnt_d;
            r_period_done_q <= w_period_done_d;
            r_seed_err_q    <= w_seed_err_d;
        end
    end

    assign o_Busy        = (r_state_q != IDLE);
    assign o_Valid       = r_valid_q;
    assign o_Rand_Data   = r_rand_q;
    assign o_LFSR_Data   = w_state;
    assign o_Step_Count  = r_step_cnt_q;
    assign o_Period_Done = r_period_done_q;
    assign o_Seed_Err    = r_seed_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prng.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_prng
// Purpose  : Self-checking bench: cycle model of a 4-bit PRNG plus width sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_prng;

    localparam int OUT = 4;
    localparam int M_TAPS [2] = '{4, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0, seed_dv = 1'b0, req = 1'b0;
    logic [3:0] seed_data = 4'h0;
    logic       busy, valid, pd, err;
    logic [3:0] rand_d, lfsr, cnt;

    lfsr_prng #(.NUM_BITS(4), .OUT_BITS(OUT), .DEFAULT_SEED(4'h0)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(seed_dv),
        .i_Seed_Data(seed_data), .i_Req(req), .o_Busy(busy), .o_Valid(valid),
        .o_Rand_Data(rand_d), .o_LFSR_Data(lfsr), .o_Step_Count(cnt),
        .o_Period_Done(pd), .o_Seed_Err(err)
    );

    // Width-sweep instances free-run from reset (seed 0).
    logic        rst_sw = 1'b1, en_sw = 1'b0;
    logic [3:0]  sw_pd, sw_busy, sw_valid, sw_err;
    logic [7:0]  r3, r8, r11, r16;
    logic [2:0]  l3, c3;
    logic [7:0]  l8, c8;
    logic [10:0] l11, c11;
    logic [15:0] l16, c16;

    lfsr_prng #(.NUM_BITS(3), .OUT_BITS(8), .DEFAULT_SEED(3'h0)) sw0 (
        .i_Clk(clk), .i_Rst(rst_sw), .i_Enable(en_sw), .i_Seed_DV(1'b0), .i_Seed_Data(3'h0),
        .i_Req(1'b0), .o_Busy(sw_busy[0]), .o_Valid(sw_valid[0]), .o_Rand_Data(r3),
        .o_LFSR_Data(l3), .o_Step_Count(c3), .o_Period_Done(sw_pd[0]), .o_Seed_Err(sw_err[0]));
    lfsr_prng #(.NUM_BITS(8), .OUT_BITS(8), .DEFAULT_SEED(8'h0)) sw1 (
        .i_Clk(clk), .i_Rst(rst_sw), .i_Enable(en_sw), .i_Seed_DV(1'b0), .i_Seed_Data(8'h0),
        .i_Req(1'b0), .o_Busy(sw_busy[1]), .o_Valid(sw_valid[1]), .o_Rand_Data(r8),
        .o_LFSR_Data(l8), .o_Step_Count(c8), .o_Period_Done(sw_pd[1]), .o_Seed_Err(sw_err[1]));
    lfsr_prng #(.NUM_BITS(11), .OUT_BITS(8), .DEFAULT_SEED(11'h0)) sw2 (
        .i_Clk(clk), .i_Rst(rst_sw), .i_Enable(en_sw), .i_Seed_DV(1'b0), .i_Seed_Data(11'h0),
        .i_Req(1'b0), .o_Busy(sw_busy[2]), .o_Valid(sw_valid[2]), .o_Rand_Data(r11),
        .o_LFSR_Data(l11), .o_Step_Count(c11), .o_Period_Done(sw_pd[2]), .o_Seed_Err(sw_err[2]));
    lfsr_prng #(.NUM_BITS(16), .OUT_BITS(8), .DEFAULT_SEED(16'h0)) sw3 (
        .i_Clk(clk), .i_Rst(rst_sw), .i_Enable(en_sw), .i_Seed_DV(1'b0), .i_Seed_Data(16'h0),
        .i_Req(1'b0), .o_Busy(sw_busy[3]), .o_Valid(sw_valid[3]), .o_Rand_Data(r16),
        .o_LFSR_Data(l16), .o_Step_Count(c16), .o_Period_Done(sw_pd[3]), .o_Seed_Err(sw_err[3]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 4-bit instance ----------------
    logic [3:0] m_lfsr = 4'h0, m_seed = 4'h0, m_coll = 4'h0, m_rand = 4'h0;
    int         m_phase = 0;   // 0 idle, 1..OUT step k, OUT+1 wrap-up, OUT+2 result cycle
    int         m_cnt = 0;
    logic       m_valid = 1'b0, m_pd = 1'b0, m_err = 1'b0;

    task automatic m_step(input int k);
        logic fb;
        fb = 1'b1;
        foreach (M_TAPS[t]) fb ^= m_lfsr[M_TAPS[t]-1];
        m_lfsr = {m_lfsr[2:0], fb};
        if (k > 0) m_coll[OUT-k] = fb;
        if (m_lfsr == m_seed) begin
            m_pd  = 1'b1;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_lfsr = 4'h0; m_seed = 4'h0; m_coll = 4'h0; m_rand = 4'h0;
            m_phase = 0; m_cnt = 0; m_valid = 1'b0; m_pd = 1'b0; m_err = 1'b0;
        end else begin
            m_pd = 1'b0; m_err = 1'b0; m_valid = 1'b0;
            if (m_phase == 0) begin
                if (seed_dv) begin
                    if (seed_data == 4'hF) begin
                        m_lfsr = 4'h0; m_seed = 4'h0; m_err = 1'b1;
                    end else begin
                        m_lfsr = seed_data; m_seed = seed_data;
                    end
                    m_cnt = 0;
                end else if (req) begin
                    m_phase = 1;
                end else if (en) begin
                    m_step(0);
                end
            end else begin
                if (seed_dv) m_err = 1'b1;
                if (m_phase <= OUT) begin
                    m_step(m_phase);
                    m_phase++;
                end else if (m_phase == OUT + 1) begin
                    m_rand  = m_coll;
                    m_valid = 1'b1;
                    m_phase++;
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    logic chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_busy",  busy,   m_phase != 0);
            chk("cmp_valid", valid,  m_valid);
            chk("cmp_rand",  rand_d, m_rand);
            chk("cmp_lfsr",  lfsr,   m_lfsr);
            chk("cmp_count", cnt,    m_cnt[3:0]);
            chk("cmp_pdone", pd,     m_pd);
            chk("cmp_serr",  err,    m_err);
        end
    end

    // ---------------- sweep bookkeeping ----------------
    int sw_steps = 0;
    int sw_first [4] = '{0, 0, 0, 0};
    int sw_second[4] = '{0, 0, 0, 0};
    int sw_cnt_at[4] = '{-1, -1, -1, -1};

    initial forever begin
        @(posedge clk);
        if (en_sw) sw_steps++;
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (sw_pd[i]) begin
                if (sw_first[i] == 0) begin
                    sw_first[i] = sw_steps;
                    case (i)
                        0: sw_cnt_at[i] = int'(c3);
                        1: sw_cnt_at[i] = int'(c8);
                        2: sw_cnt_at[i] = int'(c11);
                        default: sw_cnt_at[i] = int'(c16);
                    endcase
                end else if (sw_second[i] == 0) begin
                    sw_second[i] = sw_steps;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            lat++;
            if (valid) got = 1'b1;
        end
        chk(nm, got, 1'b1);
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] seq [7] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6};
    int lat;
    logic seen_v;
    int sw_n [4] = '{3, 8, 11, 16};

    initial begin
        tick(2);
        rst = 1'b0; rst_sw = 1'b0; en_sw = 1'b1; chk_on = 1'b1;
        chk("rst_lfsr", lfsr, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", cnt, 4'h0);

        // Draw from reset
        req = 1'b1; tick(); req = 1'b0;
        wait_valid("draw_valid_seen", lat);
        chk("draw_edges_after_accept", lat, OUT + 1);
        chk("draw_rand", rand_d, 4'hE);
        chk("draw_lfsr", lfsr, 4'hE);
        chk("draw_busy_in_result", busy, 1'b1);
        tick();
        chk("draw_valid_drop", valid, 1'b0);
        chk("draw_busy_drop", busy, 1'b0);

        // Free-run full period from seed 0
        seed_dv = 1'b1; seed_data = 4'h0; tick(); seed_dv = 1'b0;
        chk("seed_load_count", cnt, 4'h0);
        en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i <= 7) chk("free_seq", lfsr, seq[i-1]);
            if (i == 14) begin
                chk("free_count14", cnt, 4'd14);
                chk("free_pd_early", pd, 1'b0);
            end
            if (i == 15) begin
                chk("free_pd", pd, 1'b1);
                chk("free_count_wrap", cnt, 4'h0);
                chk("free_lfsr_wrap", lfsr, 4'h0);
            end
        end
        tick(3);
        en = 1'b0;

        // Lock-up seed rejected
        seed_dv = 1'b1; seed_data = 4'hF; tick(); seed_dv = 1'b0;
        chk("lock_err", err, 1'b1);
        chk("lock_lfsr", lfsr, 4'h0);
        chk("lock_count", cnt, 4'h0);
        tick();
        chk("lock_err_pulse", err, 1'b0);

        // Seed and request together: seed wins, request dropped
        seed_dv = 1'b1; seed_data = 4'h5; req = 1'b1; tick(); seed_dv = 1'b0; req = 1'b0;
        chk("conf_lfsr", lfsr, 4'h5);
        chk("conf_busy", busy, 1'b0);
        tick();
        chk("conf_busy_later", busy, 1'b0);

        // Seed strobe during SHIFT is rejected, draw unaffected
        req = 1'b1; tick(); req = 1'b0;
        tick();
        seed_dv = 1'b1; seed_data = 4'h3; tick(); seed_dv = 1'b0;
        chk("shift_seed_err", err, 1'b1);
        wait_valid("shift_valid_seen", lat);
        chk("shift_rand", rand_d, 4'h0);
        chk("shift_lfsr", lfsr, 4'h0);
        tick();

        // Reset in the middle of a draw
        req = 1'b1; tick(); req = 1'b0;
        tick(2);
        chk("mid_lfsr_before", lfsr, 4'h3);
        rst = 1'b1; #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_lfsr", lfsr, 4'h0);
        tick();
        rst = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_v |= valid;
        end
        chk("mid_no_valid", seen_v, 1'b0);

        // Width sweep: wait for the 16-bit period to elapse
        for (int k = 0; k < 70000 && sw_steps < 65540; k++) @(posedge clk);
        #1;
        chk("sweep_budget", sw_steps >= 65540, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep_first_n%0d", sw_n[i]), sw_first[i], (1 << sw_n[i]) - 1);
            chk($sformatf("sweep_count_n%0d", sw_n[i]), sw_cnt_at[i], 0);
            if (i < 3)
                chk($sformatf("sweep_spacing_n%0d", sw_n[i]),
                    sw_second[i] - sw_first[i], (1 << sw_n[i]) - 1);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
